// File: rtl/timer_avm_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// timer_avm_sequencer
//
// Purpose: Avalon-MM initiator that programs and services a 16-bit-register
// interval timer. It turns fabric start/stop/snapshot commands into timer
// register writes. It turns the timer irq into one-clock tick pulses and a
// wrapping event count.
//
// Optional feature macro: TIMER_AVM_SNAPSHOT_EN
//   defined   -> cmd_snap runs a snapshot write/read sequence and updates
//                snap_value with a one-cycle snap_valid pulse
//   undefined -> cmd_snap is ignored; snap_value and snap_valid stay 0
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_start/stop/snap   one-cycle command requests
//   cmd_period            tick period in clk cycles (sampled with cmd_start)
//   cmd_continuous        1 = periodic, 0 = one-shot (sampled with cmd_start)
//   busy                  high whenever the sequencer is not idle
//   tick                  one-cycle pulse per serviced timeout
//   event_count           serviced timeouts since reset, wraps
//   snap_value/snap_valid last snapshot counter value / update pulse
//   avm_*                 Avalon-MM initiator (registered outputs)
//   avm_readdata          read data, fixed latency 1
//   timer_irq             timer interrupt (level)
// ----------------------------------------------------------------------------
module timer_avm_sequencer #(
  parameter int EVT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_snap,
  input  logic [31:0]      cmd_period,
  input  logic             cmd_continuous,
  output logic             busy,
  output logic             tick,
  output logic [EVT_W-1:0] event_count,
  output logic [31:0]      snap_value,
  output logic             snap_valid,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  input  logic             timer_irq
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WAIT_IRQ, S_CLR_ST, S_CLR_WAIT,
    S_STOP_CTRL, S_STOP_CLR, S_SNAP_WR, S_SNAP_RDL, S_SNAP_RDH, S_SNAP_CAP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      period_q, period_d;
  logic             cont_q, cont_d;
  logic             stop_pend_q, stop_pend_d;
  logic             start_ok, stop_now;
  logic             busy_q, busy_d, tick_q, tick_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             cs_q, cs_d, wn_q, wn_d;
  logic [2:0]       addr_q, addr_d;
  logic [15:0]      wd_q, wd_d;

  assign start_ok = cmd_start && !cmd_stop;
  // A stop arriving in the decision cycle itself counts as pending.
  assign stop_now = stop_pend_q || cmd_stop;

`ifdef TIMER_AVM_SNAPSHOT_EN
  logic        snap_pend_q, snap_pend_d, snap_now;
  logic [15:0] snap_lo_q;
  logic [31:0] snap_val_q;
  logic        snap_vld_q;

  assign snap_now = snap_pend_q || cmd_snap;

  always_comb begin
    snap_pend_d = snap_pend_q;
    if (state_q != S_IDLE && cmd_snap) snap_pend_d = 1'b1;
    if (state_d == S_SNAP_WR || state_d == S_IDLE) snap_pend_d = 1'b0;
  end

  // Readdata arrives one clk after each read: low half during SNAP_RDH,
  // high half during SNAP_CAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pend_q <= 1'b0;
      snap_lo_q   <= '0;
      snap_val_q  <= '0;
      snap_vld_q  <= 1'b0;
    end else begin
      snap_pend_q <= snap_pend_d;
      snap_vld_q  <= 1'b0;
      if (state_q == S_SNAP_RDH) snap_lo_q <= avm_readdata;
      if (state_q == S_SNAP_CAP) begin
        snap_val_q <= {avm_readdata, snap_lo_q};
        snap_vld_q <= 1'b1;
      end
    end
  end

  assign snap_value = snap_val_q;
  assign snap_valid = snap_vld_q;
`else
  logic unused_snap;
  assign unused_snap = ^{cmd_snap, avm_readdata};
  assign snap_value  = '0;
  assign snap_valid  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      period_q    <= '0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      cont_q      <= cont_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: if (start_ok) begin
        state_d  = S_WR_PL;
        period_d = (cmd_period == 32'd0) ? 32'd0 : cmd_period - 32'd1;
        cont_d   = cmd_continuous;
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (stop_now)       state_d = S_STOP_CTRL;
        else if (timer_irq) state_d = S_CLR_ST;
`ifdef TIMER_AVM_SNAPSHOT_EN
        else if (snap_now)  state_d = S_SNAP_WR;
`endif
      end
      S_CLR_ST:  state_d = S_CLR_WAIT;
      // irq drops one clk after the status clear, so decide a cycle late.
      S_CLR_WAIT: begin
        if (stop_now)    state_d = S_STOP_CTRL;
        else if (cont_q) state_d = S_WAIT_IRQ;
        else             state_d = S_IDLE;
      end
      S_STOP_CTRL: state_d = S_STOP_CLR;
      S_STOP_CLR:  state_d = S_IDLE;
`ifdef TIMER_AVM_SNAPSHOT_EN
      S_SNAP_WR:   state_d = S_SNAP_RDL;
      S_SNAP_RDL:  state_d = S_SNAP_RDH;
      S_SNAP_RDH:  state_d = S_SNAP_CAP;
      S_SNAP_CAP:  state_d = S_WAIT_IRQ;
`endif
      default:     state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && cmd_stop) stop_pend_d = 1'b1;
    if (state_d == S_IDLE)             stop_pend_d = 1'b0;
  end

  // Output decode from the next state so every bus signal is registered
  // and lines up with the state it belongs to.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 3'd0;
    wd_d   = 16'd0;
    tick_d = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_WR_PL:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd2; wd_d = period_d[15:0]; end
      S_WR_PH:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd3; wd_d = period_d[31:16]; end
      S_WR_CTRL:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1;
                         wd_d = {12'h000, 1'b0, 1'b1, cont_d, 1'b1}; end
      S_CLR_ST:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; tick_d = 1'b1; end
      S_STOP_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd1; wd_d = 16'h0008; end
      S_STOP_CLR:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd0; end
`ifdef TIMER_AVM_SNAPSHOT_EN
      S_SNAP_WR:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 3'd4; end
      S_SNAP_RDL:  begin cs_d = 1'b1; addr_d = 3'd4; end
      S_SNAP_RDH:  begin cs_d = 1'b1; addr_d = 3'd5; end
`endif
      default: ;
    endcase
    evt_d = tick_d ? evt_q + EVT_W'(1) : evt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      tick_q <= 1'b0;
      evt_q  <= '0;
      cs_q   <= 1'b0;
      wn_q   <= 1'b1;
      addr_q <= 3'd0;
      wd_q   <= 16'd0;
    end else begin
      busy_q <= busy_d;
      tick_q <= tick_d;
      evt_q  <= evt_d;
      cs_q   <= cs_d;
      wn_q   <= wn_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
    end
  end

  assign busy           = busy_q;
  assign tick           = tick_q;
  assign event_count    = evt_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = wd_q;

endmodule

// File: tb/tb_timer_avm_sequencer.sv
`timescale 1ns/1ps
// Bench for timer_avm_sequencer with a behavioural interval-timer model on
// the Avalon bus. Expected bus accesses and snapshot values are queued when
// stimulus is driven and popped by the negedge monitor.
module tb_timer_avm_sequencer;
  localparam int EVT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_start, cmd_stop, cmd_snap, cmd_continuous;
  logic [31:0]      cmd_period;
  logic             busy, tick, snap_valid;
  logic [EVT_W-1:0] event_count;
  logic [31:0]      snap_value;
  logic [2:0]       avm_address;
  logic             avm_chipselect, avm_write_n;
  logic [15:0]      avm_writedata, avm_readdata;
  logic             timer_irq;

  always #5 clk = ~clk;

  timer_avm_sequencer #(.EVT_W(EVT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .busy(busy), .tick(tick), .event_count(event_count),
    .snap_value(snap_value), .snap_valid(snap_valid),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .timer_irq(timer_irq)
  );

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int exp_ec = 0;
  int bus_cnt = 0;
  int tick_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- interval timer model ----------------
  logic [31:0] m_period, m_counter, m_snap, m_force_val;
  logic        m_running, m_to, m_ito, m_cont, m_force;
  logic [15:0] m_rdata;

  assign timer_irq    = m_to & m_ito;
  assign avm_readdata = m_rdata;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_period <= '0; m_counter <= '0; m_snap <= '0; m_running <= 1'b0;
      m_to <= 1'b0; m_ito <= 1'b0; m_cont <= 1'b0; m_rdata <= '0;
    end else begin
      if (m_force) m_counter <= m_force_val;
      else if (m_running) begin
        if (m_counter == 32'd0) begin
          m_to <= 1'b1;
          if (m_cont) m_counter <= m_period;
          else        m_running <= 1'b0;
        end else m_counter <= m_counter - 32'd1;
      end
      m_rdata <= 16'h0;
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito  <= avm_writedata[0];
            m_cont <= avm_writedata[1];
            if (avm_writedata[2]) begin m_running <= 1'b1; m_counter <= m_period; end
            if (avm_writedata[3]) m_running <= 1'b0;
          end
          3'd2: m_period[15:0]  <= avm_writedata;
          3'd3: m_period[31:16] <= avm_writedata;
          3'd4, 3'd5: m_snap <= m_counter;
          default: ;
        endcase
      end else if (avm_chipselect) begin
        if (avm_address == 3'd4)      m_rdata <= m_snap[15:0];
        else if (avm_address == 3'd5) m_rdata <= m_snap[31:16];
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] snap_q[$];

  always @(negedge clk) begin
    acc_t got, e;
    logic [31:0] es;
    if (reset_n) begin
      total++;
      if (avm_chipselect) begin
        bus_cnt++;
        got = {!avm_write_n, avm_address, avm_writedata};
        $display("bus %s addr=%0d data=%h at cyc %0d", got.wr ? "wr" : "rd",
                 got.addr, got.data, cyc);
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL bus_unexpected got wr=%0b addr=%0d data=%h required no access",
                   got.wr, got.addr, got.data);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL bus_access got wr=%0b addr=%0d data=%h required wr=%0b addr=%0d data=%h",
                     got.wr, got.addr, got.data, e.wr, e.addr, e.data);
          end
        end
      end else if ({avm_write_n, avm_address, avm_writedata} !== {1'b1, 3'd0, 16'd0}) begin
        bad++;
        $display("FAIL bus_idle got write_n=%0b addr=%0d data=%h required 1/0/0000",
                 avm_write_n, avm_address, avm_writedata);
      end
      if (tick) tick_cnt++;
      if (snap_valid) begin
        total++;
        if (snap_q.size() == 0) begin
          bad++;
          $display("FAIL snap_unexpected got snap_value=%h required no snap_valid", snap_value);
        end else begin
          es = snap_q.pop_front();
          if (snap_value !== es) begin
            bad++;
            $display("FAIL snap_value got %h required %h", snap_value, es);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_wr(input logic [2:0] a, input logic [15:0] d);
    acc_t e;
    e.wr = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [2:0] a);
    acc_t e;
    e.wr = 1'b0; e.addr = a; e.data = 16'h0;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge of cycle 1 (first bus write); c1 = cyc there.
  task automatic start_cmd(input logic [31:0] period, input logic cont,
                           output int unsigned c1);
    logic [31:0] p;
    p = (period == 32'd0) ? 32'd0 : period - 32'd1;
    push_wr(3'd2, p[15:0]);
    push_wr(3'd3, p[31:16]);
    push_wr(3'd1, {12'h000, 1'b0, 1'b1, cont, 1'b1});
    @(negedge clk);
    cmd_period = period; cmd_continuous = cont; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    c1 = cyc;
  endtask

  task automatic stop_cmd();
    push_wr(3'd1, 16'h0008);
    push_wr(3'd0, 16'h0000);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tick(input int budget, output bit ok, output int unsigned t);
    ok = 1'b0; t = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick) begin ok = 1'b1; t = cyc; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    cmd_start = 0; cmd_stop = 0; cmd_snap = 0; cmd_continuous = 0; cmd_period = 0;
    m_force = 1'b0; m_force_val = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, tick, event_count, snap_value, snap_valid, avm_address, avm_chipselect,
         avm_write_n, avm_writedata} !==
        {1'b0, 1'b0, {EVT_W{1'b0}}, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL reset_state got busy=%0b tick=%0b ec=%h cs=%0b wn=%0b addr=%0d wd=%h required 0/0/0/0/1/0/0",
               busy, tick, event_count, avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_oneshot();
    int unsigned c1;
    bit ok;
    int t0;
    t0 = tick_cnt;
    start_cmd(32'd10, 1'b0, c1);
    push_wr(3'd0, 16'h0000);
    total++;
    if (!(busy === 1'b1 && avm_address === 3'd2 && avm_write_n === 1'b0)) begin
      bad++;
      $display("FAIL start_latency got busy=%0b addr=%0d wn=%0b required 1/2/0", busy, avm_address, avm_write_n);
    end
    repeat (2) @(negedge clk);
    total++;
    if (!(avm_address === 3'd1 && avm_chipselect === 1'b1)) begin
      bad++;
      $display("FAIL ctrl_latency got addr=%0d cs=%0b required 1/1", avm_address, avm_chipselect);
    end
    wait_not_busy(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL oneshot_done got busy=1 required busy=0"); end
    exp_ec += 1;
    total++;
    if (tick_cnt - t0 !== 1) begin
      bad++; $display("FAIL oneshot_ticks got %0d required 1", tick_cnt - t0);
    end
    total++;
    if (event_count !== EVT_W'(exp_ec)) begin
      bad++; $display("FAIL oneshot_ec got %0d required %0d", event_count, exp_ec);
    end
    $display("test_oneshot done ec=%0d", event_count);
  endtask

  task automatic test_reset_mid();
    push_wr(3'd2, 16'd99);
    push_wr(3'd3, 16'd0);
    @(negedge clk);
    cmd_period = 32'd100; cmd_continuous = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    @(negedge clk);
    total++;
    if (!(avm_address === 3'd3 && avm_chipselect === 1'b1)) begin
      bad++; $display("FAIL mid_wr_ph got addr=%0d cs=%0b required 3/1", avm_address, avm_chipselect);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({busy, tick, event_count, avm_chipselect, avm_write_n, avm_address, avm_writedata} !==
        {1'b0, 1'b0, {EVT_W{1'b0}}, 1'b0, 1'b1, 3'd0, 16'h0}) begin
      bad++;
      $display("FAIL mid_reset got busy=%0b ec=%h cs=%0b wn=%0b addr=%0d wd=%h required 0/0/0/1/0/0",
               busy, event_count, avm_chipselect, avm_write_n, avm_address, avm_writedata);
    end
    exp_ec = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_idle got busy=%0b required 0", busy); end
    $display("test_reset_mid done");
  endtask

  task automatic test_cont_50000();
    int unsigned c1, t;
    bit ok;
    start_cmd(32'd50000, 1'b1, c1);
    push_wr(3'd0, 16'h0000);
    wait_tick(60000, ok, t);
    total++;
    if (!ok) begin bad++; $display("FAIL cont_tick_timeout got no tick required tick"); end
    total++;
    if (t - (c1 + 2) !== 50002) begin
      bad++; $display("FAIL cont_tick_delay got %0d required 50002", t - (c1 + 2));
    end
    stop_cmd();
    wait_not_busy(20, ok);
    exp_ec += 1;
    total++;
    if (!ok || event_count !== EVT_W'(exp_ec)) begin
      bad++; $display("FAIL cont_stop got busy=%0b ec=%0d required 0/%0d", busy, event_count, exp_ec);
    end
    $display("test_cont_50000 done");
  endtask

  task automatic test_periodic();
    int unsigned c1, t1, t2, t3;
    bit ok1, ok2, ok3, ok;
    start_cmd(32'd200, 1'b1, c1);
    repeat (3) push_wr(3'd0, 16'h0000);
    wait_tick(400, ok1, t1);
    @(negedge clk);
    total++;
    if (tick !== 1'b0) begin bad++; $display("FAIL tick_width got tick=%0b required 0", tick); end
    wait_tick(400, ok2, t2);
    wait_tick(400, ok3, t3);
    total++;
    if (!(ok1 && ok2 && ok3) || t2 - t1 !== 200 || t3 - t2 !== 200) begin
      bad++; $display("FAIL tick_spacing got %0d,%0d required 200,200", t2 - t1, t3 - t2);
    end
    stop_cmd();
    wait_not_busy(20, ok);
    exp_ec += 3;
    total++;
    if (!ok || event_count !== EVT_W'(exp_ec)) begin
      bad++; $display("FAIL periodic_ec got %0d required %0d", event_count, exp_ec);
    end
    $display("test_periodic done");
  endtask

  task automatic test_stop_on_irq();
    int unsigned c1;
    int t0, b0;
    bit ok;
    t0 = tick_cnt;
    start_cmd(32'd10, 1'b1, c1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (timer_irq) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL stop_irq_timeout got no irq required irq"); end
    stop_cmd();
    wait_not_busy(20, ok);
    b0 = bus_cnt;
    repeat (30) @(negedge clk);
    total++;
    if (!ok || tick_cnt != t0 || event_count !== EVT_W'(exp_ec) || bus_cnt != b0) begin
      bad++;
      $display("FAIL stop_on_irq got ticks=%0d ec=%0d extra_bus=%0d required 0/%0d/0",
               tick_cnt - t0, event_count, bus_cnt - b0, exp_ec);
    end
    $display("test_stop_on_irq done");
  endtask

  task automatic test_edges();
    int unsigned c1;
    int b0;
    bit ok;
    start_cmd(32'd0, 1'b0, c1);
    push_wr(3'd0, 16'h0000);
    wait_not_busy(30, ok);
    exp_ec += 1;
    total++;
    if (!ok || event_count !== EVT_W'(exp_ec)) begin
      bad++; $display("FAIL period0 got ec=%0d required %0d", event_count, exp_ec);
    end
    b0 = bus_cnt;
    cmd_period = 32'd5; cmd_start = 1'b1; cmd_stop = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus_cnt != b0) begin
      bad++; $display("FAIL start_stop_idle got busy=%0b bus=%0d required 0/0", busy, bus_cnt - b0);
    end
    $display("test_edges done");
  endtask

  task automatic test_wrap();
    int unsigned c1;
    bit ok, all_ok;
    all_ok = 1'b1;
    while ((exp_ec % (1 << EVT_W)) != ((1 << EVT_W) - 1)) begin
      start_cmd(32'd2, 1'b0, c1);
      push_wr(3'd0, 16'h0000);
      wait_not_busy(30, ok);
      all_ok &= ok;
      exp_ec += 1;
    end
    total++;
    if (!all_ok || event_count !== {EVT_W{1'b1}}) begin
      bad++; $display("FAIL wrap_max got %h required all ones", event_count);
    end
    start_cmd(32'd2, 1'b0, c1);
    push_wr(3'd0, 16'h0000);
    wait_not_busy(30, ok);
    exp_ec += 1;
    total++;
    if (!ok || event_count !== {EVT_W{1'b0}}) begin
      bad++; $display("FAIL wrap_zero got %h required 0", event_count);
    end
    $display("test_wrap done");
  endtask

  task automatic test_snap();
    int unsigned c1;
    int b0, t0;
    bit ok;
    start_cmd(32'h0010_0000, 1'b1, c1);
    repeat (3) @(negedge clk);
    m_force_val = 32'h0001_2345;
    m_force = 1'b1;
`ifdef TIMER_AVM_SNAPSHOT_EN
    push_wr(3'd4, 16'h0000);
    push_rd(3'd4);
    push_rd(3'd5);
    snap_q.push_back(32'h0001_2345);
    cmd_snap = 1'b1;
    @(negedge clk);
    cmd_snap = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (snap_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!ok) begin bad++; $display("FAIL snap_timeout got no snap_valid required pulse"); end
    @(negedge clk);
    total++;
    if (snap_valid !== 1'b0 || snap_value !== 32'h0001_2345) begin
      bad++; $display("FAIL snap_pulse got valid=%0b value=%h required 0/00012345", snap_valid, snap_value);
    end
`else
    b0 = bus_cnt;
    cmd_snap = 1'b1;
    @(negedge clk);
    cmd_snap = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (bus_cnt != b0 || snap_value !== 32'h0) begin
      bad++; $display("FAIL snap_disabled got bus=%0d value=%h required 0/0", bus_cnt - b0, snap_value);
    end
`endif
    m_force = 1'b0;
    t0 = tick_cnt;
    stop_cmd();
    wait_not_busy(20, ok);
    total++;
    if (!ok || tick_cnt != t0) begin
      bad++; $display("FAIL snap_stop got busy=%0b ticks=%0d required 0/0", busy, tick_cnt - t0);
    end
    $display("test_snap done");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reset_mid();
    test_cont_50000();
    test_periodic();
    test_stop_on_irq();
    test_edges();
    test_wrap();
    test_snap();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || snap_q.size() != 0) begin
      bad++; $display("FAIL leftover_expected got %0d/%0d required 0/0", exp_q.size(), snap_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
